// File: rtl/point_stream_sink_pkg.sv
// Shared types and helpers for the point stream sink: FSM state encoding,
// counter width and a saturating increment.
package point_stream_sink_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fb_bitmap.sv
// 1-bit framebuffer: FB_H rows of FB_W bits with whole-row clear, single-bit
// set, a registered readback port and a combinational peek at the set address.
module fb_bitmap #(
  parameter  int FB_W = 32,
  parameter  int FB_H = 32,
  localparam int XW   = $clog2(FB_W),
  localparam int YW   = $clog2(FB_H)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_en_i,
  input  logic [YW-1:0] clr_row_i,
  input  logic          set_en_i,
  input  logic [XW-1:0] set_x_i,
  input  logic [YW-1:0] set_y_i,
  input  logic [XW-1:0] rd_x_i,
  input  logic [YW-1:0] rd_y_i,
  output logic          peek_o,
  output logic          rd_pixel_o
);

  logic [FB_W-1:0] mem_q [FB_H];
  logic            rd_pixel_q;

  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      mem_q[clr_row_i] <= '0;
    end else if (set_en_i) begin
      mem_q[set_y_i][set_x_i] <= 1'b1;
    end
  end

  // Read sees the array before this edge's write, so same-cycle reads return old data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rd_pixel_q <= 1'b0;
    else         rd_pixel_q <= mem_q[rd_y_i][rd_x_i];
  end

  // Writes land at the edge, so a back-to-back beat already sees the previous set here.
  assign peek_o     = mem_q[set_y_i][set_x_i];
  assign rd_pixel_o = rd_pixel_q;

endmodule

// File: rtl/point_stream_sink.sv
// Stream sink: clears the framebuffer, launches a generator, rasterises its
// coordinate beats with clipping, counts hits/clips and ends on done or timeout.
// Handshake: a beat transfers on a rising edge where _in_valid && _in_ready;
// _in_ready is high only in COLLECT and does not depend on _in_valid.
module point_stream_sink
  import point_stream_sink_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FB_W    = 32,
  parameter int FB_H    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      _clock,
  input  logic                      _reset,
  input  logic                      _start,
  output logic                      _gen_start,
  input  logic signed [WIDTH-1:0]   _in0,
  input  logic signed [WIDTH-1:0]   _in1,
  input  logic                      _in_valid,
  output logic                      _in_ready,
  input  logic                      _gen_done,
  input  logic [$clog2(FB_W)-1:0]   rd_x,
  input  logic [$clog2(FB_H)-1:0]   rd_y,
  output logic                      rd_pixel,
  output logic [15:0]               _count,
  output logic [15:0]               _unique,
  output logic [15:0]               _clipped,
  output logic                      _timeout,
  output logic                      _done,
  output logic [2:0]                dbg_state
);

  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [YW-1:0]        row_q;
  logic [TW-1:0]        to_q;
  logic [COUNT_W-1:0]   count_q, unique_q, clipped_q;
  logic                 timeout_q;
  logic                 accept, in_range, idle_hit, launch_run, peek;

  assign accept     = _in_valid && _in_ready;
  // Power-of-two bounds: in range iff every bit above the index (sign included) is zero.
  assign in_range   = (_in0[WIDTH-1:XW] == '0) && (_in1[WIDTH-1:YW] == '0);
  assign idle_hit   = (state_q == ST_COLLECT) && !_in_valid && !_gen_done &&
                      (to_q == TW'(TIMEOUT - 1));
  assign launch_run = _start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge _clock) begin
    if (!_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (_start) state_d = ST_CLEAR;
      ST_CLEAR:   if (row_q == YW'(FB_H - 1)) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_COLLECT;
      ST_COLLECT: if (_gen_done || idle_hit) state_d = ST_DONE;
      ST_DONE:    if (_start) state_d = ST_CLEAR;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    _gen_start = (state_q == ST_LAUNCH);
    _in_ready  = (state_q == ST_COLLECT);
    _done      = (state_q == ST_DONE);
  end

  always_ff @(posedge _clock) begin
    if (!_reset || launch_run) begin
      row_q     <= '0;
      to_q      <= '0;
      count_q   <= '0;
      unique_q  <= '0;
      clipped_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR)  row_q <= row_q + 1'b1;
      if (state_q == ST_LAUNCH) to_q  <= '0;
      if (state_q == ST_COLLECT) begin
        if (accept)          to_q <= '0;
        else if (!_gen_done) to_q <= to_q + 1'b1;
        if (idle_hit) timeout_q <= 1'b1;
        if (accept) begin
          if (in_range) begin
            count_q <= sat_inc(count_q);
            if (!peek) unique_q <= sat_inc(unique_q);
          end else begin
            clipped_q <= sat_inc(clipped_q);
          end
        end
      end
    end
  end

  fb_bitmap #(.FB_W(FB_W), .FB_H(FB_H)) u_fb (
    .clk_i      (_clock),
    .rst_ni     (_reset),
    .clr_en_i   (state_q == ST_CLEAR),
    .clr_row_i  (row_q),
    .set_en_i   (accept && in_range),
    .set_x_i    (_in0[XW-1:0]),
    .set_y_i    (_in1[YW-1:0]),
    .rd_x_i     (rd_x),
    .rd_y_i     (rd_y),
    .peek_o     (peek),
    .rd_pixel_o (rd_pixel)
  );

  assign _count    = count_q;
  assign _unique   = unique_q;
  assign _clipped  = clipped_q;
  assign _timeout  = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_point_stream_sink.sv
// Directed bench for point_stream_sink: clear/launch sequencing, rasterising,
// clipping, duplicate beats, done-with-beat, timeout and mid-run reset.
module tb_point_stream_sink;
  import point_stream_sink_pkg::*;

  logic               _clock = 1'b0;
  logic               _reset = 1'b0;
  logic               _start = 1'b0;
  logic               _gen_start;
  logic signed [31:0] _in0 = '0;
  logic signed [31:0] _in1 = '0;
  logic               _in_valid = 1'b0;
  logic               _in_ready;
  logic               _gen_done = 1'b0;
  logic [4:0]         rd_x = '0;
  logic [4:0]         rd_y = '0;
  logic               rd_pixel;
  logic [15:0]        _count, _unique, _clipped;
  logic               _timeout, _done;
  logic [2:0]         dbg_state;

  int checks = 0;
  int errors = 0;

  point_stream_sink #(.WIDTH(32), .FB_W(32), .FB_H(32), .TIMEOUT(16)) dut (
    ._clock    (_clock),
    ._reset    (_reset),
    ._start    (_start),
    ._gen_start(_gen_start),
    ._in0      (_in0),
    ._in1      (_in1),
    ._in_valid (_in_valid),
    ._in_ready (_in_ready),
    ._gen_done (_gen_done),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_pixel  (rd_pixel),
    ._count    (_count),
    ._unique   (_unique),
    ._clipped  (_clipped),
    ._timeout  (_timeout),
    ._done     (_done),
    .dbg_state (dbg_state)
  );

  always #5 _clock = ~_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge _clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y);
    _in0 = x; _in1 = y; _in_valid = 1'b1;
    tick();
    _in_valid = 1'b0;
  endtask

  task automatic gen_done_pulse();
    _gen_done = 1'b1;
    tick();
    _gen_done = 1'b0;
  endtask

  task automatic start_run();
    _start = 1'b1;
    tick();
    _start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input state_e s);
    int n = 0;
    while (dbg_state != s && n < 200) begin
      tick();
      n++;
    end
    chk(tag, dbg_state, s);
  endtask

  task automatic read_px(input string tag, input int x, input int y, input logic exp);
    rd_x = x[4:0]; rd_y = y[4:0];
    tick();
    chk(tag, rd_pixel, exp);
  endtask

  task automatic scan_ones(output int n);
    n = 0;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        rd_x = x[4:0]; rd_y = y[4:0];
        tick();
        n += int'(rd_pixel);
      end
    end
  endtask

  initial begin
    int n;

    // Reset state
    tick(); tick();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ready", _in_ready, 1'b0);
    chk("rst_done", _done, 1'b0);
    chk("rst_gen_start", _gen_start, 1'b0);
    chk("rst_timeout", _timeout, 1'b0);
    chk("rst_count", _count, 16'd0);
    chk("rst_rd_pixel", rd_pixel, 1'b0);
    _reset = 1'b1;
    tick();

    // Run 1: clear length, launch pulse, three in-range beats
    start_run();
    n = 0;
    while (dbg_state == ST_CLEAR && n < 100) begin
      n++;
      tick();
    end
    chk("clear_cycles", n, 32);
    chk("launch_state", dbg_state, ST_LAUNCH);
    chk("gen_start_hi", _gen_start, 1'b1);
    tick();
    chk("collect_state", dbg_state, ST_COLLECT);
    chk("gen_start_lo", _gen_start, 1'b0);
    chk("collect_ready", _in_ready, 1'b1);
    send(3, 4); send(31, 31); send(0, 0);
    gen_done_pulse();
    chk("r1_done", _done, 1'b1);
    chk("r1_count", _count, 16'd3);
    chk("r1_unique", _unique, 16'd3);
    chk("r1_clipped", _clipped, 16'd0);
    chk("r1_timeout", _timeout, 1'b0);
    chk("r1_ready_lo", _in_ready, 1'b0);
    read_px("px_3_4", 3, 4, 1'b1);
    read_px("px_31_31", 31, 31, 1'b1);
    read_px("px_0_0", 0, 0, 1'b1);
    read_px("px_4_3", 4, 3, 1'b0);
    read_px("px_1_0", 1, 0, 1'b0);

    // Run 2: clipped beats only, frame must be fully clear afterwards
    start_run();
    chk("r2_clear_state", dbg_state, ST_CLEAR);
    chk("r2_count_zeroed", _count, 16'd0);
    chk("r2_done_lo", _done, 1'b0);
    wait_state("r2_wait_collect", ST_COLLECT);
    send(-1, 5); send(32, 0); send(5, 40);
    gen_done_pulse();
    chk("r2_clipped", _clipped, 16'd3);
    chk("r2_count", _count, 16'd0);
    chk("r2_unique", _unique, 16'd0);
    scan_ones(n);
    chk("r2_frame_ones", n, 0);

    // Run 3: duplicate back-to-back beat, then beat together with done
    start_run();
    wait_state("r3_wait_collect", ST_COLLECT);
    send(7, 7); send(7, 7);
    chk("r3_dup_count", _count, 16'd2);
    chk("r3_dup_unique", _unique, 16'd1);
    _in0 = 9; _in1 = 2; _in_valid = 1'b1; _gen_done = 1'b1;
    tick();
    _in_valid = 1'b0; _gen_done = 1'b0;
    chk("r3_state_done", dbg_state, ST_DONE);
    chk("r3_count", _count, 16'd3);
    chk("r3_unique", _unique, 16'd2);
    read_px("px_7_7", 7, 7, 1'b1);
    read_px("px_9_2", 9, 2, 1'b1);

    // Run 4: timeout after 16 idle cycles, restart clears flag and counters
    start_run();
    wait_state("r4_wait_collect", ST_COLLECT);
    n = 0;
    while (dbg_state == ST_COLLECT && n < 100) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 16);
    chk("to_done", _done, 1'b1);
    chk("to_flag", _timeout, 1'b1);
    chk("to_count", _count, 16'd0);
    start_run();
    chk("to_restart_state", dbg_state, ST_CLEAR);
    chk("to_restart_flag", _timeout, 1'b0);
    chk("to_restart_done", _done, 1'b0);

    // Run 5: reset in the middle of COLLECT
    wait_state("r5_wait_collect", ST_COLLECT);
    send(1, 1);
    chk("r5_count_pre", _count, 16'd1);
    _reset = 1'b0;
    tick();
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_ready", _in_ready, 1'b0);
    chk("mid_rst_count", _count, 16'd0);
    chk("mid_rst_done", _done, 1'b0);
    _reset = 1'b1;
    tick();
    chk("post_rst_idle", dbg_state, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
